idec_pipe: RTL and testbench
============================

Name: idec_pipe

Overview:
- Registered, handshaked ARM-subset instruction decoder that sits between fetch and execute.
- Decodes data-processing, load/store and branch instructions into control fields, and evaluates the condition code against the NZCV flags.
- Tracks in-flight flag-setting instructions and stalls conditional instructions until their flags commit.
- After a taken branch, squashes a parametrised number of fetch-shadow instructions.

Parameters:
- PC_W, 32, width of the sign-extended branch byte offset (minimum 26).
- BR_SHADOW, 2, number of accepted instructions dropped after a taken branch (0..7).
- MAX_FLAG_INFLIGHT, 3, maximum number of outstanding S-instructions handed to execute (1..15).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  fetch holds a valid instruction.
- in_ready  out  1  decoder accepts the instruction this cycle.
- in_instr  in  32  instruction word.
- flags_in  in  4  committed NZCV flags, {N,Z,C,V}.
- flags_commit  in  1  one-cycle pulse: execute has retired one S-instruction.
- flush  in  1  kill the output register and the branch shadow.
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  execute accepts the bundle.
- out_nop  out  1  condition failed; all enables are 0.
- out_undef  out  1  unsupported encoding; all enables are 0.
- out_alu_op  out  4  in_instr[24:21] for data-processing; 4'b0100 (ADD) for load/store address.
- out_rn, out_rd, out_rm  out  4 each  fields [19:16], [15:12], [3:0].
- out_imm_sel  out  1  operand 2 is an immediate.
- out_imm  out  12  [11:0] (data-processing with I=1, or load/store with I=0).
- out_shift_type  out  2  [6:5]; out_shift_amt  out  5  [11:7].
- out_set_flags, out_reg_we, out_mem_we, out_mem_re  out  1 each.
- out_mem_pre, out_mem_up, out_mem_wb  out  1 each  P/U/W, bits 24/23/21.
- out_branch, out_link  out  1 each.
- out_br_off  out  PC_W  sign-extended {imm24, 2'b00}.

Behaviour:
- Reset: every output register is 0, out_valid=0, shadow counter=0, pending-flag counter=0. in_ready is combinational and follows the rules below.
- Handshakes: an instruction is accepted when in_valid && in_ready. The output register loads on the next rising edge, so latency is 1 cycle. out_valid holds, with all fields stable, until out_ready.
- in_ready = (!out_valid || out_ready) && !stall && !flush.
- Shadow: while shadow counter != 0, accepted instructions are discarded. No out_valid is raised, and the counter decrements once per acceptance.
- Condition check (cond = [31:28]):
  - EQ/NE test Z; CS/CC test C; MI/PL test N; VS/VC test V.
  - HI = C && !Z; LS = !C || Z.
  - GE = N==V; LT = N!=V; GT = !Z && N==V; LE = Z || N!=V.
  - AL (1110) always passes; 1111 is treated as undef.
  - A failing instruction is emitted with out_nop=1 and all enables 0.
- Stall: if cond != AL and the pending counter != 0, the instruction waits because the flags are stale. If the pending counter == MAX_FLAG_INFLIGHT, any instruction with S=1 waits.
- Pending counter:
  - +1 on an output handshake where out_set_flags=1 and out_nop=0.
  - -1 on flags_commit.
  - Both in the same cycle: no change.
  - flags_commit while the counter is 0 is ignored.
- Decode, by [27:25]:
  - 00x is data-processing. reg_we=1 except for TST/TEQ/CMP/CMN (10xx with S=1), where reg_we=0. set_flags=[20]; imm_sel=[25].
  - 01x is load/store. L=[20] gives mem_re=reg_we=1; !L gives mem_we=1. imm_sel = ![25]. set_flags=0.
  - 101 is branch. out_branch=1, out_link=[24]. out_reg_we = out_link, with out_rd forced to 14. On handshake the shadow counter loads BR_SHADOW.
  - Any other value sets out_undef=1.
- Data-processing with bit [4]=1 (register-specified shift) is flagged undef.
- Nop and undef bundles never load the shadow counter and never increment the pending counter.
- flush:
  - Synchronous. Next edge: out_valid=0 and shadow counter=0. The pending counter is untouched.
  - A flush in the same cycle as an output handshake keeps that handshake, since the bundle was consumed.
- Reset mid-operation: all state clears asynchronously. The in-flight bundle is lost.

Decomposition:
- Package idec_pkg holds:
  - Condition-code constants (COND_EQ .. COND_AL).
  - Opcode-class constants (OPC_DP, OPC_LS, OPC_BR).
  - ALU opcode constants, including ALU_ADD.
  - The decoded-bundle struct.
- Sub-module cond_eval (combinational, cond + NZCV to pass) is reused by execute.

Test Plan:
- 0xE0912003 (ADDS r2,r1,r3) → next cycle out_valid=1, alu_op=0100, rn=1, rd=2, rm=3, set_flags=1, reg_we=1. After the handshake the pending counter is 1.
- Following 0x00812003 (ADDEQ), sent in the cycle after that handshake → in_ready=0 until a flags_commit pulse. Then, with flags_in=4'b0000, the bundle is emitted with out_nop=1 and reg_we=0.
- 0xE5910004 (LDR r0,[r1,#4]) → mem_re=1, reg_we=1, mem_pre=1, mem_up=1, imm=4, imm_sel=1, alu_op=0100. 0xE5810004 (STR) → mem_we=1, reg_we=0.
- 0xEAFFFFFE (B .) → out_branch=1, out_br_off=0xFFFFFFF8. The next 2 accepted words produce no output, and the third is emitted.
- 0xEB000001 (BL) → out_link=1, reg_we=1, rd=14, br_off=4. A flush asserted during the shadow clears it, so the next instruction is emitted.
- Stall out_ready low for 3 cycles with a valid bundle → fields stable and in_ready=0. Deassert rst_n mid-stall → out_valid drops immediately.

Source files
------------

// File: rtl/idec_pkg.sv
// Shared encodings and the decoded-bundle type for the ARM-subset decoder.
// cond_eval and the execute stage use the same constants.
package idec_pkg;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  // Class is matched on [27:26] for DP/LS and on [27:25] for branches.
  localparam logic [1:0] OPC_DP = 2'b00;
  localparam logic [1:0] OPC_LS = 2'b01;
  localparam logic [2:0] OPC_BR = 3'b101;

  localparam logic [3:0] ALU_AND = 4'h0;
  localparam logic [3:0] ALU_EOR = 4'h1;
  localparam logic [3:0] ALU_SUB = 4'h2;
  localparam logic [3:0] ALU_RSB = 4'h3;
  localparam logic [3:0] ALU_ADD = 4'h4;
  localparam logic [3:0] ALU_ADC = 4'h5;
  localparam logic [3:0] ALU_SBC = 4'h6;
  localparam logic [3:0] ALU_RSC = 4'h7;
  localparam logic [3:0] ALU_TST = 4'h8;
  localparam logic [3:0] ALU_TEQ = 4'h9;
  localparam logic [3:0] ALU_CMP = 4'hA;
  localparam logic [3:0] ALU_CMN = 4'hB;
  localparam logic [3:0] ALU_ORR = 4'hC;
  localparam logic [3:0] ALU_MOV = 4'hD;
  localparam logic [3:0] ALU_BIC = 4'hE;
  localparam logic [3:0] ALU_MVN = 4'hF;

  typedef struct packed {
    logic        nop;
    logic        undef;
    logic [3:0]  alu_op;
    logic [3:0]  rn;
    logic [3:0]  rd;
    logic [3:0]  rm;
    logic        imm_sel;
    logic [11:0] imm;
    logic [1:0]  shift_type;
    logic [4:0]  shift_amt;
    logic        set_flags;
    logic        reg_we;
    logic        mem_we;
    logic        mem_re;
    logic        mem_pre;
    logic        mem_up;
    logic        mem_wb;
    logic        branch;
    logic        link;
  } idec_bundle_t;

  // Full decode of one word; pass is the condition-check result.
  function automatic idec_bundle_t idec_decode(input logic [31:0] instr, input logic pass);
    idec_bundle_t b;
    logic is_dp, is_ls, is_br, bad;
    b          = '0;
    is_dp      = (instr[27:26] == OPC_DP);
    is_ls      = (instr[27:26] == OPC_LS);
    is_br      = (instr[27:25] == OPC_BR);
    b.rn       = instr[19:16];
    b.rd       = instr[15:12];
    b.rm       = instr[3:0];
    b.imm      = instr[11:0];
    b.shift_type = instr[6:5];
    b.shift_amt  = instr[11:7];
    // Register-specified shifts (I=0, bit 4 set) are not supported.
    bad = (instr[31:28] == COND_NV) || !(is_dp || is_ls || is_br) ||
          (is_dp && !instr[25] && instr[4]);
    if (is_dp) begin
      b.alu_op    = instr[24:21];
      b.imm_sel   = instr[25];
      b.set_flags = instr[20];
      b.reg_we    = !((instr[24:23] == 2'b10) && instr[20]);
    end else if (is_ls) begin
      b.alu_op  = ALU_ADD;
      b.imm_sel = !instr[25];
      b.mem_re  = instr[20];
      b.reg_we  = instr[20];
      b.mem_we  = !instr[20];
      b.mem_pre = instr[24];
      b.mem_up  = instr[23];
      b.mem_wb  = instr[21];
    end else if (is_br) begin
      b.branch = 1'b1;
      b.link   = instr[24];
      b.reg_we = instr[24];
      b.rd     = 4'd14;
    end
    if (bad || !pass) begin
      b.undef     = bad;
      b.nop       = !bad;
      b.set_flags = 1'b0;
      b.reg_we    = 1'b0;
      b.mem_we    = 1'b0;
      b.mem_re    = 1'b0;
      b.branch    = 1'b0;
      b.link      = 1'b0;
    end
    return b;
  endfunction

endpackage

// File: rtl/idec_pipe_cond_eval.sv
// Condition-code evaluator: cond field against committed NZCV.
// Purely combinational; NV (1111) never passes.
module cond_eval
  import idec_pkg::*;
(
  input  logic [3:0] i_cond,
  input  logic [3:0] i_nzcv,
  output logic       o_pass
);

  logic w_n, w_z, w_c, w_v;
  assign {w_n, w_z, w_c, w_v} = i_nzcv;

  always_comb begin
    // NOTE: default assignment first so every path drives o_pass and no latch is inferred.
    o_pass = 1'b0;
    case (i_cond)
      COND_EQ: o_pass = w_z;
      COND_NE: o_pass = !w_z;
      COND_CS: o_pass = w_c;
      COND_CC: o_pass = !w_c;
      COND_MI: o_pass = w_n;
      COND_PL: o_pass = !w_n;
      COND_VS: o_pass = w_v;
      COND_VC: o_pass = !w_v;
      COND_HI: o_pass = w_c && !w_z;
      COND_LS: o_pass = !w_c || w_z;
      COND_GE: o_pass = (w_n == w_v);
      COND_LT: o_pass = (w_n != w_v);
      COND_GT: o_pass = !w_z && (w_n == w_v);
      COND_LE: o_pass = w_z || (w_n != w_v);
      COND_AL: o_pass = 1'b1;
      default: o_pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/idec_pipe.sv
// Registered, handshaked ARM-subset decoder between fetch and execute, with
// flag-hazard stalling and branch-shadow squashing.
module idec_pipe
  import idec_pkg::*;
#(
  parameter int PC_W              = 32,
  parameter int BR_SHADOW         = 2,
  parameter int MAX_FLAG_INFLIGHT = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [3:0]      flags_in,
  input  logic            flags_commit,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_nop,
  output logic            out_undef,
  output logic [3:0]      out_alu_op,
  output logic [3:0]      out_rn,
  output logic [3:0]      out_rd,
  output logic [3:0]      out_rm,
  output logic            out_imm_sel,
  output logic [11:0]     out_imm,
  output logic [1:0]      out_shift_type,
  output logic [4:0]      out_shift_amt,
  output logic            out_set_flags,
  output logic            out_reg_we,
  output logic            out_mem_we,
  output logic            out_mem_re,
  output logic            out_mem_pre,
  output logic            out_mem_up,
  output logic            out_mem_wb,
  output logic            out_branch,
  output logic            out_link,
  output logic [PC_W-1:0] out_br_off
);

  localparam logic [2:0] SHADOW_INIT = 3'(BR_SHADOW);
  localparam logic [4:0] PEND_MAX    = 5'(MAX_FLAG_INFLIGHT);

  logic               w_pass;
  idec_bundle_t       w_dec;
  logic signed [25:0] w_off26;
  logic [PC_W-1:0]    w_br_off;
  logic               w_s_instr;
  logic               w_stall;
  logic               w_accept;
  logic               w_out_hs;
  logic               w_pend_inc;
  logic               w_pend_dec;

  idec_bundle_t       r_out;
  logic [PC_W-1:0]    r_br_off;
  logic               r_valid;
  logic [2:0]         r_shadow;
  logic [4:0]         r_pend;

  cond_eval u_cond_eval (
    .i_cond (in_instr[31:28]),
    .i_nzcv (flags_in),
    .o_pass (w_pass)
  );

  assign w_dec    = idec_decode(in_instr, w_pass);
  assign w_off26  = {in_instr[23:0], 2'b00};
  assign w_br_off = PC_W'(w_off26);

  // Conditionals must see committed flags; S-instructions are throttled at the in-flight limit.
  assign w_s_instr = (in_instr[27:26] == OPC_DP) && in_instr[20];
  assign w_stall   = ((in_instr[31:28] != COND_AL) && (r_pend != 5'd0)) ||
                     (w_s_instr && (r_pend >= PEND_MAX));

  assign in_ready   = (!r_valid || out_ready) && !w_stall && !flush;
  assign w_accept   = in_valid && in_ready;
  assign w_out_hs   = r_valid && out_ready;
  assign w_pend_inc = w_out_hs && r_out.set_flags && !r_out.nop;
  assign w_pend_dec = flags_commit && (r_pend != 5'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the output register is part of the visible interface, so it is reset to zero along with the control state.
    if (!rst_n) begin
      r_out    <= '0;
      r_br_off <= '0;
      r_valid  <= 1'b0;
      r_shadow <= 3'd0;
      r_pend   <= 5'd0;
    end else begin
      // NOTE: non-blocking assignments keep every register update based on pre-edge values.
      if (flush) begin
        r_valid  <= 1'b0;
        r_shadow <= 3'd0;
      end else if (w_accept) begin
        if (r_shadow != 3'd0) begin
          r_shadow <= r_shadow - 3'd1;
          if (w_out_hs) r_valid <= 1'b0;
        end else begin
          r_valid  <= 1'b1;
          r_out    <= w_dec;
          r_br_off <= w_br_off;
          if (w_dec.branch) r_shadow <= SHADOW_INIT;
        end
      end else if (w_out_hs) begin
        r_valid <= 1'b0;
      end

      case ({w_pend_inc, w_pend_dec})
        2'b10:   r_pend <= r_pend + 5'd1;
        2'b01:   r_pend <= r_pend - 5'd1;
        default: r_pend <= r_pend;
      endcase
    end
  end

  assign out_valid      = r_valid;
  assign out_nop        = r_out.nop;
  assign out_undef      = r_out.undef;
  assign out_alu_op     = r_out.alu_op;
  assign out_rn         = r_out.rn;
  assign out_rd         = r_out.rd;
  assign out_rm         = r_out.rm;
  assign out_imm_sel    = r_out.imm_sel;
  assign out_imm        = r_out.imm;
  assign out_shift_type = r_out.shift_type;
  assign out_shift_amt  = r_out.shift_amt;
  assign out_set_flags  = r_out.set_flags;
  assign out_reg_we     = r_out.reg_we;
  assign out_mem_we     = r_out.mem_we;
  assign out_mem_re     = r_out.mem_re;
  assign out_mem_pre    = r_out.mem_pre;
  assign out_mem_up     = r_out.mem_up;
  assign out_mem_wb     = r_out.mem_wb;
  assign out_branch     = r_out.branch;
  assign out_link       = r_out.link;
  assign out_br_off     = r_br_off;

endmodule

// File: tb/tb_idec_pipe.sv
// Directed bench for idec_pipe: decode fields, condition checks, flag stalls,
// branch shadow, flush, output back-pressure and asynchronous reset.
module tb_idec_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [3:0]  flags_in;
  logic        flags_commit;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic        out_nop, out_undef;
  logic [3:0]  out_alu_op, out_rn, out_rd, out_rm;
  logic        out_imm_sel;
  logic [11:0] out_imm;
  logic [1:0]  out_shift_type;
  logic [4:0]  out_shift_amt;
  logic        out_set_flags, out_reg_we, out_mem_we, out_mem_re;
  logic        out_mem_pre, out_mem_up, out_mem_wb, out_branch, out_link;
  logic [31:0] out_br_off;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  idec_pipe dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_instr       (in_instr),
    .flags_in       (flags_in),
    .flags_commit   (flags_commit),
    .flush          (flush),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_nop        (out_nop),
    .out_undef      (out_undef),
    .out_alu_op     (out_alu_op),
    .out_rn         (out_rn),
    .out_rd         (out_rd),
    .out_rm         (out_rm),
    .out_imm_sel    (out_imm_sel),
    .out_imm        (out_imm),
    .out_shift_type (out_shift_type),
    .out_shift_amt  (out_shift_amt),
    .out_set_flags  (out_set_flags),
    .out_reg_we     (out_reg_we),
    .out_mem_we     (out_mem_we),
    .out_mem_re     (out_mem_re),
    .out_mem_pre    (out_mem_pre),
    .out_mem_up     (out_mem_up),
    .out_mem_wb     (out_mem_wb),
    .out_branch     (out_branch),
    .out_link       (out_link),
    .out_br_off     (out_br_off)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a word, wait (bounded) for in_ready, and return just after the accepting edge.
  task automatic accept(input string tag, input logic [31:0] instr);
    int n = 0;
    in_valid = 1'b1;
    in_instr = instr;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    check({tag, "_rdy"}, 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
  endtask

  typedef struct {
    logic [31:0] instr;
    logic [3:0]  flags;
    logic        nop;
    logic        undef;
  } vec_t;

  vec_t vecs [0:8];

  initial begin
    vecs = '{
      '{32'h00812003, 4'b0100, 1'b0, 1'b0},  // EQ, Z=1
      '{32'hC0812003, 4'b1001, 1'b0, 1'b0},  // GT, N=V, Z=0
      '{32'hC0812003, 4'b1000, 1'b1, 1'b0},  // GT, N!=V
      '{32'h90812003, 4'b0010, 1'b1, 1'b0},  // LS, C=1 Z=0
      '{32'h80812003, 4'b0010, 1'b0, 1'b0},  // HI, C=1 Z=0
      '{32'hB0812003, 4'b1000, 1'b0, 1'b0},  // LT, N!=V
      '{32'hF0812003, 4'b0000, 1'b0, 1'b1},  // cond 1111
      '{32'hEE000000, 4'b0000, 1'b0, 1'b1},  // class 111
      '{32'hE0812113, 4'b0000, 1'b0, 1'b1}   // register-specified shift
    };

    rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; flags_in = 4'b0000;
    flags_commit = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_alu_op", 32'(out_alu_op), 32'd0);
    check("rst_br_off", out_br_off, 32'd0);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // ADDS r2,r1,r3
    step();
    accept("adds", 32'hE0912003);
    check("adds_valid", 32'(out_valid), 32'd1);
    check("adds_alu", 32'(out_alu_op), 32'h4);
    check("adds_rn", 32'(out_rn), 32'd1);
    check("adds_rd", 32'(out_rd), 32'd2);
    check("adds_rm", 32'(out_rm), 32'd3);
    check("adds_sf", 32'(out_set_flags), 32'd1);
    check("adds_we", 32'(out_reg_we), 32'd1);
    step();

    // ADDEQ must wait for the ADDS flags to commit
    in_valid = 1'b1;
    in_instr = 32'h00812003;
    #1;
    check("addeq_stall0", 32'(in_ready), 32'd0);
    step();
    check("addeq_stall1", 32'(in_ready), 32'd0);
    flags_commit = 1'b1;
    step();
    flags_commit = 1'b0;
    #1;
    check("addeq_release", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    check("addeq_valid", 32'(out_valid), 32'd1);
    check("addeq_nop", 32'(out_nop), 32'd1);
    check("addeq_we", 32'(out_reg_we), 32'd0);
    step();

    // LDR r0,[r1,#4] / STR r0,[r1,#4]
    accept("ldr", 32'hE5910004);
    check("ldr_re", 32'(out_mem_re), 32'd1);
    check("ldr_we", 32'(out_reg_we), 32'd1);
    check("ldr_mwe", 32'(out_mem_we), 32'd0);
    check("ldr_pre", 32'(out_mem_pre), 32'd1);
    check("ldr_up", 32'(out_mem_up), 32'd1);
    check("ldr_wb", 32'(out_mem_wb), 32'd0);
    check("ldr_imm", 32'(out_imm), 32'd4);
    check("ldr_isel", 32'(out_imm_sel), 32'd1);
    check("ldr_alu", 32'(out_alu_op), 32'h4);
    check("ldr_rn", 32'(out_rn), 32'd1);
    step();
    accept("str", 32'hE5810004);
    check("str_mwe", 32'(out_mem_we), 32'd1);
    check("str_we", 32'(out_reg_we), 32'd0);
    check("str_re", 32'(out_mem_re), 32'd0);
    step();

    // Fill the in-flight limit of 3 S-instructions, then a 4th must wait
    for (int i = 0; i < 3; i++) begin
      accept($sformatf("fill%0d", i), 32'hE0912003);
      step();
    end
    in_valid = 1'b1;
    in_instr = 32'hE0912003;
    #1;
    check("max_stall0", 32'(in_ready), 32'd0);
    step();
    check("max_stall1", 32'(in_ready), 32'd0);
    flags_commit = 1'b1;
    step();
    flags_commit = 1'b0;
    #1;
    check("max_release", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    check("max_valid", 32'(out_valid), 32'd1);
    step();
    for (int i = 0; i < 4; i++) begin  // three real commits plus one at zero
      flags_commit = 1'b1;
      step();
      flags_commit = 1'b0;
    end

    // ADDNE must not stall: counter is back at zero and ignored the extra commit
    in_valid = 1'b1;
    in_instr = 32'h10812003;
    #1;
    check("addne_nostall", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    check("addne_nop", 32'(out_nop), 32'd0);
    check("addne_we", 32'(out_reg_we), 32'd1);
    step();

    // Condition codes and undefined encodings
    foreach (vecs[i]) begin
      flags_in = vecs[i].flags;
      accept($sformatf("vec%0d", i), vecs[i].instr);
      check($sformatf("vec%0d_nop", i), 32'(out_nop), 32'(vecs[i].nop));
      check($sformatf("vec%0d_undef", i), 32'(out_undef), 32'(vecs[i].undef));
      check($sformatf("vec%0d_we", i), 32'(out_reg_we), 32'(!(vecs[i].nop || vecs[i].undef)));
      step();
    end
    flags_in = 4'b0000;

    // B . then two shadow words dropped, third emitted
    accept("b", 32'hEAFFFFFE);
    check("b_branch", 32'(out_branch), 32'd1);
    check("b_off", out_br_off, 32'hFFFFFFF8);
    check("b_link", 32'(out_link), 32'd0);
    check("b_we", 32'(out_reg_we), 32'd0);
    step();
    accept("sh0", 32'hE0812003);
    check("sh0_valid", 32'(out_valid), 32'd0);
    accept("sh1", 32'hE0812003);
    check("sh1_valid", 32'(out_valid), 32'd0);
    accept("sh2", 32'hE0823004);
    check("sh2_valid", 32'(out_valid), 32'd1);
    check("sh2_rd", 32'(out_rd), 32'd3);
    step();

    // BL, then flush clears the shadow
    accept("bl", 32'hEB000001);
    check("bl_link", 32'(out_link), 32'd1);
    check("bl_we", 32'(out_reg_we), 32'd1);
    check("bl_rd", 32'(out_rd), 32'd14);
    check("bl_off", out_br_off, 32'd4);
    step();
    flush = 1'b1;
    in_valid = 1'b1;
    in_instr = 32'hE0823004;
    #1;
    check("flush_rdy", 32'(in_ready), 32'd0);
    step();
    flush = 1'b0;
    accept("postflush", 32'hE0823004);
    check("postflush_valid", 32'(out_valid), 32'd1);
    check("postflush_rd", 32'(out_rd), 32'd3);
    step();

    // Back-pressure: bundle holds, fields stable, input blocked; then async reset
    out_ready = 1'b0;
    accept("bp", 32'hE0823004);
    in_valid = 1'b1;
    in_instr = 32'hE5910004;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("bp%0d_valid", i), 32'(out_valid), 32'd1);
      check($sformatf("bp%0d_rdy", i), 32'(in_ready), 32'd0);
      check($sformatf("bp%0d_fields", i), {20'd0, out_rn, out_rd, out_rm}, {20'd0, 4'd2, 4'd3, 4'd4});
      step();
    end
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(out_valid), 32'd0);
    check("async_rst_rd", 32'(out_rd), 32'd0);
    in_valid = 1'b0;
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    check("post_rst_valid", 32'(out_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
